// File: rtl/tmr_voter_reg_pkg.sv
// tmr_voter_reg_pkg: operating-mode encoding shared by the TMR voter register.
package tmr_voter_reg_pkg;

    typedef enum logic [1:0] {
        TMR      = 2'd0,
        DEGRADED = 2'd1,
        FAILED   = 2'd2
    } mode_t;

    function automatic logic [1:0] popcnt3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/maj3_n.sv
// maj3_n: combinational bitwise 2-of-3 majority over WIDTH-bit words.
module maj3_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/tmr_voter_reg.sv
// tmr_voter_reg: registered TMR voter with per-channel error counters and sticky fault flags.
// Define TMR_VOTER_DEGRADE_EN to enable DEGRADED/FAILED operation after channel faults.
module tmr_voter_reg
    import tmr_voter_reg_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CNT_W        = 4,
    parameter int FAULT_THRESH = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    input  logic               clr_faults,
    output logic               valid_out,
    output logic [WIDTH-1:0]   vote_out,
    output logic               mismatch,
    output logic [2:0]         ch_fault,
    output logic [3*CNT_W-1:0] err_cnt,
    output logic [1:0]         mode
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(FAULT_THRESH);

    logic [WIDTH-1:0] maj;
    logic [WIDTH-1:0] word [3];
    logic [WIDTH-1:0] fvote;
    logic [WIDTH-1:0] vote_n;
    logic [CNT_W-1:0] cnt [3];
    logic [CNT_W-1:0] cnt_n [3];
    logic [2:0]       err;
    logic [1:0]       lo;
    logic [1:0]       hi;
    logic             mis_n;
    mode_t            state;
    mode_t            eff;

    maj3_n #(.WIDTH(WIDTH)) u_maj (.a(a), .b(b), .c(c), .y(maj));

    assign word  = '{a, b, c};
    assign mode  = state;
    // Healthy pair in DEGRADED: the two channels other than the lowest faulted one.
    assign lo    = ch_fault[0] ? 2'd1 : 2'd0;
    assign hi    = (ch_fault[0] | ch_fault[1]) ? 2'd2 : 2'd1;
    assign fvote = !ch_fault[0] ? a : !ch_fault[1] ? b : !ch_fault[2] ? c : a;

`ifdef TMR_VOTER_DEGRADE_EN
    assign eff = clr_faults ? TMR : state;
`else
    assign eff = TMR;
`endif

    for (genvar i = 0; i < 3; i++) begin : g_cnt
        assign err_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end

    always_comb begin
        err    = '0;
        vote_n = maj;
        mis_n  = 1'b0;
        if (eff == TMR) begin
            for (int i = 0; i < 3; i++) err[i] = word[i] != maj;
            mis_n = |err;
        end else if (eff == DEGRADED) begin
            vote_n  = word[lo];
            mis_n   = word[lo] != word[hi];
            err[lo] = mis_n;
            err[hi] = mis_n;
        end else begin
            vote_n = fvote;
        end
        for (int i = 0; i < 3; i++)
            cnt_n[i] = (valid_in && err[i] && !ch_fault[i] && cnt[i] != CNT_MAX) ? cnt[i] + 1'b1 : cnt[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            vote_out  <= '0;
            mismatch  <= 1'b0;
            ch_fault  <= '0;
            state     <= TMR;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                vote_out <= vote_n;
                mismatch <= mis_n;
            end
            if (clr_faults) begin
                ch_fault <= '0;
                state    <= TMR;
                for (int i = 0; i < 3; i++) cnt[i] <= '0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    cnt[i] <= cnt_n[i];
                    if (cnt_n[i] >= THRESH) ch_fault[i] <= 1'b1;
                end
`ifdef TMR_VOTER_DEGRADE_EN
                if (valid_in)
                    state <= (popcnt3(ch_fault) >= 2'd2) ? FAILED :
                             (popcnt3(ch_fault) == 2'd1 && state == TMR) ? DEGRADED : state;
`endif
            end
        end
    end

endmodule

// File: tb/tb_tmr_voter_reg.sv
// tb_tmr_voter_reg: random and directed checks of two voter configurations against a behavioural model.
module tb_tmr_voter_reg;

`ifdef TMR_VOTER_DEGRADE_EN
    localparam bit DEG = 1'b1;
`else
    localparam bit DEG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_in = 1'b0;
    logic clr_faults = 1'b0;
    logic [7:0] a = '0, b = '0, c = '0;

    logic v0, mm0, v1, mm1;
    logic [7:0] vo0, vo1;
    logic [2:0] cf0, cf1;
    logic [11:0] ec0;
    logic [5:0] ec1;
    logic [1:0] md0, md1;

    int n_vec = 0;
    int n_err = 0;

    int m_cnt [2][3];
    bit m_flt [2][3];
    int m_mode [2];
    logic [7:0] m_vote [2];
    bit m_mis [2];
    bit m_vo [2];
    int cmax [2] = '{15, 3};
    int cw [2] = '{4, 2};

    tmr_voter_reg #(.WIDTH(8), .CNT_W(4), .FAULT_THRESH(3)) d0 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .a(a), .b(b), .c(c),
        .clr_faults(clr_faults), .valid_out(v0), .vote_out(vo0), .mismatch(mm0),
        .ch_fault(cf0), .err_cnt(ec0), .mode(md0)
    );

    tmr_voter_reg #(.WIDTH(8), .CNT_W(2), .FAULT_THRESH(3)) d1 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .a(a), .b(b), .c(c),
        .clr_faults(clr_faults), .valid_out(v1), .vote_out(vo1), .mismatch(mm1),
        .ch_fault(cf1), .err_cnt(ec1), .mode(md1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[k][i] = 0;
                m_flt[k][i] = 1'b0;
            end
            m_mode[k] = 0;
            m_vote[k] = '0;
            m_mis[k]  = 1'b0;
            m_vo[k]   = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        logic [7:0] w [3];
        logic [7:0] mj, vote;
        bit e [3];
        bit mis;
        int md, nf, ex, ones;
        int pr [$];
        w = '{a, b, c};
        mj = '0;
        for (int bt = 0; bt < 8; bt++) begin
            ones = 0;
            for (int i = 0; i < 3; i++) ones += int'(w[i][bt]);
            mj[bt] = ones >= 2;
        end
        md = (clr_faults || !DEG) ? 0 : m_mode[k];
        e = '{1'b0, 1'b0, 1'b0};
        mis = 1'b0;
        vote = mj;
        if (md == 0) begin
            for (int i = 0; i < 3; i++) e[i] = w[i] != mj;
            mis = e[0] | e[1] | e[2];
        end else if (md == 1) begin
            ex = -1;
            for (int i = 0; i < 3; i++) if (m_flt[k][i] && ex < 0) ex = i;
            if (ex < 0) ex = 2;
            for (int i = 0; i < 3; i++) if (i != ex) pr.push_back(i);
            vote = w[pr[0]];
            mis = w[pr[0]] != w[pr[1]];
            e[pr[0]] = mis;
            e[pr[1]] = mis;
        end else begin
            vote = a;
            for (int i = 2; i >= 0; i--) if (!m_flt[k][i]) vote = w[i];
        end
        m_vo[k] = valid_in;
        if (valid_in) begin
            m_vote[k] = vote;
            m_mis[k]  = mis;
        end
        if (clr_faults) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[k][i] = 0;
                m_flt[k][i] = 1'b0;
            end
            m_mode[k] = 0;
        end else if (valid_in) begin
            nf = 0;
            for (int i = 0; i < 3; i++) nf += int'(m_flt[k][i]);
            if (DEG && nf >= 2) m_mode[k] = 2;
            else if (DEG && nf == 1 && m_mode[k] == 0) m_mode[k] = 1;
            for (int i = 0; i < 3; i++)
                if (e[i] && !m_flt[k][i]) begin
                    if (m_cnt[k][i] < cmax[k]) m_cnt[k][i]++;
                    if (m_cnt[k][i] >= 3) m_flt[k][i] = 1'b1;
                end
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int k);
        logic [31:0] r = '0;
        for (int i = 0; i < 3; i++) r |= 32'(m_cnt[k][i]) << (i * cw[k]);
        return r;
    endfunction

    function automatic logic [31:0] exp_flt(input int k);
        return {29'd0, m_flt[k][2], m_flt[k][1], m_flt[k][0]};
    endfunction

    task automatic check_all();
        chk("valid_out0", 32'(v0), 32'(m_vo[0]));
        chk("vote_out0", 32'(vo0), 32'(m_vote[0]));
        chk("mismatch0", 32'(mm0), 32'(m_mis[0]));
        chk("ch_fault0", 32'(cf0), exp_flt(0));
        chk("err_cnt0", 32'(ec0), exp_cnt(0));
        chk("mode0", 32'(md0), 32'(m_mode[0]));
        chk("valid_out1", 32'(v1), 32'(m_vo[1]));
        chk("vote_out1", 32'(vo1), 32'(m_vote[1]));
        chk("mismatch1", 32'(mm1), 32'(m_mis[1]));
        chk("ch_fault1", 32'(cf1), exp_flt(1));
        chk("err_cnt1", 32'(ec1), exp_cnt(1));
        chk("mode1", 32'(md1), 32'(m_mode[1]));
    endtask

    task automatic step(input bit v, input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic, input bit clr);
        valid_in = v;
        a = ia;
        b = ib;
        c = ic;
        clr_faults = clr;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [7:0] base;
        logic [7:0] w [3];
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        step(1, 8'h5A, 8'h5A, 8'h5A, 0);
        chk("r034_vote", 32'(vo0), 32'h5A);
        chk("r034_mis", 32'(mm0), 32'h0);
        chk("r034_cnt", 32'(ec0), 32'h0);

        for (int n = 0; n < 3; n++) begin
            step(1, 8'hFF, 8'h0F, 8'h0F, 0);
            chk("r035_vote", 32'(vo0), 32'h0F);
        end
        chk("r035_cnt", 32'(ec0), 32'h003);
        chk("r035_flt", 32'(cf0), 32'h1);
        step(1, 8'h0F, 8'h0F, 8'h0F, 0);
        chk("r035_mode", 32'(md0), DEG ? 32'h1 : 32'h0);

        step(1, 8'h00, 8'h11, 8'h22, 0);
        chk("r036_vote", 32'(vo0), DEG ? 32'h11 : 32'h00);
        chk("r036_mis", 32'(mm0), 32'h1);
        chk("r036_cnt", 32'(ec0), 32'h113);

        step(1, 8'hFF, 8'h00, 8'h00, 1);
        chk("r037_cnt", 32'(ec0), 32'h0);
        chk("r037_flt", 32'(cf0), 32'h0);
        chk("r037_mode", 32'(md0), 32'h0);
        chk("r037_vote", 32'(vo0), 32'h00);

        for (int n = 0; n < 5; n++) step(1, 8'h00, 8'h00, 8'h01, 0);
        chk("r039_cnt", 32'(ec1), 32'h30);
        chk("r039_flt", 32'(cf1), 32'h4);
        step(0, 8'h00, 8'h00, 8'h00, 1);

        for (int n = 0; n < 400; n++) begin
            base = 8'($urandom);
            for (int i = 0; i < 3; i++)
                w[i] = ($urandom_range(0, 3) == 0) ? base ^ 8'($urandom_range(1, 255)) : base;
            step($urandom_range(0, 4) != 0, w[0], w[1], w[2], $urandom_range(0, 59) == 0);
        end

        valid_in = 1'b1;
        clr_faults = 1'b0;
        a = 8'h3C;
        b = 8'h3C;
        c = 8'hC3;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 8'h00, 8'h00, 8'h00, 0);
        chk("r038_novalid", 32'(v0), 32'h0);
        step(1, 8'h77, 8'h77, 8'h76, 0);
        chk("r029_valid", 32'(v0), 32'h1);
        chk("r029_vote", 32'(vo0), 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tmr_voter_reg.md
TMR_VOTER_REG -- requirements
Module: tmr_voter_reg

Interface
REQ-001 Parameter WIDTH, default 8, voted data width in bits.
REQ-002 Parameter CNT_W, default 4, width of each per-channel error counter.
REQ-003 Parameter FAULT_THRESH, default 3, error count at which a channel is declared faulted; legal range 1 to 2^CNT_W-1.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 valid_in  input  1  a, b and c carry a sample this cycle.
REQ-007 a, b, c  input  WIDTH each  redundant channel words 0, 1 and 2.
REQ-008 clr_faults  input  1  synchronous clear of counters, fault flags and mode.
REQ-009 valid_out  output  1  vote_out is valid this cycle.
REQ-010 vote_out  output  WIDTH  registered voted word.
REQ-011 mismatch  output  1  the healthy channels disagreed on the last accepted sample.
REQ-012 ch_fault  output  3  sticky per-channel fault flag; bit i maps to channel i.
REQ-013 err_cnt  output  3*CNT_W  per-channel counters; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-014 mode  output  2  operating state: 0 TMR, 1 DEGRADED, 2 FAILED.

Function
REQ-015 Latency is exactly one cycle: valid_out equals valid_in delayed by one clock, and vote_out and mismatch update only on accepted samples.
REQ-016 When valid_in is low, vote_out, mismatch, err_cnt and mode hold their values.
REQ-017 In TMR, vote_out is the bitwise majority (a&b)|(a&c)|(b&c).
REQ-018 In TMR, channel i is in error when its word differs from the majority word, and mismatch is high when any channel is in error.
REQ-019 Each channel in error on an accepted sample increments its counter by 1, saturating at 2^CNT_W-1.
REQ-020 ch_fault[i] sets in the cycle its counter reaches FAULT_THRESH and stays set until clr_faults or reset.
REQ-021 TMR goes to DEGRADED when exactly one ch_fault bit is set, and to FAILED when two or more are set; the mode change takes effect on the sample after the one that set the flag.
REQ-022 In DEGRADED, vote_out is the lower-index healthy channel, mismatch is high when the two healthy channels differ, and both healthy counters increment on mismatch.
REQ-023 In FAILED, vote_out is the lowest-index unfaulted channel (channel 0 when all three are faulted), mismatch is 0, and the counters hold.
REQ-024 Counters of faulted channels freeze.
REQ-025 There is no path out of DEGRADED or FAILED except clr_faults or reset.
REQ-026 clr_faults zeroes all counters, clears ch_fault and sets mode to TMR; an error on a sample accepted in the same cycle is discarded, while the vote_out and valid_out updates still occur in TMR form.
REQ-027 When two channels reach FAULT_THRESH on the same sample, mode goes directly to FAILED.

Reset
REQ-028 While rst_n is low, all outputs and counters are 0, ch_fault is 000 and mode is TMR, independent of clk.
REQ-029 A reset asserted mid-stream discards any in-flight sample, and the first valid_in after deassertion produces valid_out one cycle later.

Configuration
REQ-030 With TMR_VOTER_DEGRADE_EN defined, REQ-021 to REQ-025 and REQ-027 apply.
REQ-031 Without TMR_VOTER_DEGRADE_EN, mode stays 0, voting is always the TMR majority, counters and ch_fault still update (faulted channel counters freeze), and clr_faults still clears.

Structure
REQ-032 A shared package holds the mode encoding constants (TMR, DEGRADED, FAILED) and the 2-bit mode type.
REQ-033 The combinational bitwise majority is a sub-module named maj3_n, parametrised by WIDTH; the counters and mode FSM reside in tmr_voter_reg.

Verification
REQ-034 Reset, then a=b=c=8'h5A with valid_in high -> next cycle vote_out=8'h5A, mismatch=0, err_cnt=0.
REQ-035 a=8'hFF, b=c=8'h0F on 3 consecutive valid samples -> vote_out=8'h0F each time, counter 0 reaches 3, ch_fault=001, and mode=1 on the following sample.
REQ-036 In DEGRADED with channel 0 faulted, drive b=8'h11, c=8'h22 -> vote_out=8'h11, mismatch=1, and counters 1 and 2 each increment.
REQ-037 Assert clr_faults in the same cycle as an erroneous sample -> all counters 0, ch_fault=000, mode=0.
REQ-038 Drive rst_n low asynchronously between clock edges while valid_in is high -> outputs go to 0 immediately, with no valid_out pulse after release.
REQ-039 With CNT_W=2 and FAULT_THRESH=3, apply 5 errors on channel 2 -> its counter saturates at 3 and is frozen once faulted.
